// File: rtl/bus_source_decoder.sv
// Bus source decoder: turns a 5-bit source code into a one-hot drive
// enable for 24 bus sources. Whenever the source changes, a configurable
// number of dead cycles (all enables low) separates the two drivers so
// that two sources never fight on the bus.
module bus_source_decoder #(
  parameter int unsigned GAP_CYCLES = 1   // dead cycles on a source switch, 1..7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  sel_i,
  input  logic        sel_valid_i,
  input  logic        release_i,
  input  logic        err_clr_i,
  output logic [23:0] out_en_o,
  output logic [4:0]  cur_code_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned NUM_SRC  = 24;
  localparam logic [2:0]  GAP_LOAD = 3'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e              state_q;
  logic [4:0]          code_q;
  logic [4:0]          pend_q;
  logic [2:0]          cnt_q;
  logic [NUM_SRC-1:0]  out_en_q;
  logic                busy_q;
  logic                err_q;

  logic                req_take;
  logic                req_legal;
  logic                req_illegal;
  logic                err_d;
  logic [4:0]          pend_d;

  // Codes 24..31 name no source.
  function automatic logic is_legal(input logic [4:0] code);
    return code < 5'(NUM_SRC);
  endfunction

  // One-hot enable for a code; illegal codes decode to no enable at all.
  function automatic logic [NUM_SRC-1:0] onehot(input logic [4:0] code);
    logic [NUM_SRC-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      v[i] = (code == 5'(i));
    end
    return v;
  endfunction

  // Request qualification: release masks sel_valid entirely, so a
  // simultaneous illegal code neither switches nor flags an error.
  always_comb begin
    req_take    = sel_valid_i & ~release_i;
    req_legal   = req_take & is_legal(sel_i);
    req_illegal = req_take & ~is_legal(sel_i);
    // A new illegal request wins over a coincident clear.
    err_d       = req_illegal | (err_q & ~err_clr_i);
    // Latest legal request during the gap replaces the pending code.
    pend_d      = req_legal ? sel_i : pend_q;
  end

  // Source-select FSM; every output comes straight from a register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      out_en_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_IDLE: begin
          out_en_q <= '0;
          busy_q   <= 1'b0;
          if (req_legal) begin
            code_q   <= sel_i;
            out_en_q <= onehot(sel_i);
            state_q  <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          if (release_i) begin
            out_en_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (req_legal && (sel_i != code_q)) begin
            // Switch: drop the current driver now, bring the new one up
            // only after the dead time has elapsed.
            pend_q   <= sel_i;
            cnt_q    <= GAP_LOAD;
            out_en_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_GAP;
          end
          // Same code or illegal code: enable held unchanged.
        end

        S_GAP: begin
          if (release_i) begin
            pend_q   <= '0;
            cnt_q    <= '0;
            out_en_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (cnt_q <= 3'd1) begin
            // Last dead cycle: the pending source (including one
            // requested on this very cycle) takes the bus.
            code_q   <= pend_d;
            out_en_q <= onehot(pend_d);
            pend_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_DRIVE;
          end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_q - 3'd1;
            out_en_q <= '0;
            busy_q   <= 1'b1;
          end
        end

        default: begin
          pend_q   <= '0;
          cnt_q    <= '0;
          out_en_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign out_en_o   = out_en_q;
  assign cur_code_o = code_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_bus_source_decoder.sv
// Bench for bus_source_decoder: two instances (gap of 1 and of 3 cycles)
// share one stimulus stream; a timeline model predicts every output.
module tb_bus_source_decoder;

  logic        clk;
  logic        reset;
  logic [4:0]  sel;
  logic        sel_valid;
  logic        rel;
  logic        err_clr;

  logic [23:0] oe0, oe1;
  logic [4:0]  cc0, cc1;
  logic        bz0, bz1;
  logic        er0, er1;

  int compared   = 0;
  int mismatched = 0;
  bit run        = 0;

  bus_source_decoder #(.GAP_CYCLES(1)) dut0 (
    .clk_i(clk), .reset_i(reset), .sel_i(sel), .sel_valid_i(sel_valid),
    .release_i(rel), .err_clr_i(err_clr),
    .out_en_o(oe0), .cur_code_o(cc0), .busy_o(bz0), .err_o(er0));

  bus_source_decoder #(.GAP_CYCLES(3)) dut1 (
    .clk_i(clk), .reset_i(reset), .sel_i(sel), .sel_valid_i(sel_valid),
    .release_i(rel), .err_clr_i(err_clr),
    .out_en_o(oe1), .cur_code_o(cc1), .busy_o(bz1), .err_o(er1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: which source drives, which waits, and the cycle at
  // which the waiting one takes over (-1 means none).
  int gap_of[2] = '{1, 3};
  int drv[2], pend[2], due[2], cur[2];
  bit merr[2];
  int n = 0;

  always @(posedge clk) begin
    bit legal, illegal;
    n++;
    legal   = sel_valid && !rel && (int'(sel) < 24);
    illegal = sel_valid && !rel && (int'(sel) >= 24);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        drv[k] = -1; pend[k] = -1; due[k] = 0; cur[k] = 0; merr[k] = 0;
      end else begin
        merr[k] = (merr[k] && !err_clr) || illegal;
        if (rel) begin
          drv[k] = -1; pend[k] = -1;
        end else if (pend[k] >= 0) begin
          if (legal) pend[k] = int'(sel);
          if (n >= due[k]) begin
            drv[k] = pend[k]; cur[k] = pend[k]; pend[k] = -1;
          end
        end else if (drv[k] >= 0) begin
          if (legal && int'(sel) != drv[k]) begin
            pend[k] = int'(sel); drv[k] = -1; due[k] = n + gap_of[k];
          end
        end else if (legal) begin
          drv[k] = int'(sel); cur[k] = int'(sel);
        end
      end
    end
  end

  // Every cycle: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        logic [23:0] e_oe;
        e_oe = (drv[k] >= 0) ? (24'd1 << drv[k]) : 24'd0;
        chk($sformatf("model g%0d out_en", gap_of[k]), (k == 0) ? oe0 : oe1, e_oe);
        chk($sformatf("model g%0d busy", gap_of[k]), (k == 0) ? bz0 : bz1, pend[k] >= 0);
        chk($sformatf("model g%0d err", gap_of[k]), (k == 0) ? er0 : er1, merr[k]);
        if (drv[k] >= 0)
          chk($sformatf("model g%0d cur_code", gap_of[k]), (k == 0) ? cc0 : cc1, cur[k]);
      end
    end
  end

  task automatic drive(input logic [4:0] s, input logic v, input logic r,
                       input logic c, input logic rs);
    sel = s; sel_valid = v; rel = r; err_clr = c; reset = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    sel = '0; sel_valid = 0; rel = 0; err_clr = 0; reset = 1;
    @(negedge clk);
    chk("reset out_en", oe0, 0);      chk("reset cur_code", cc0, 0);
    chk("reset busy", bz0, 0);        chk("reset err", er0, 0);
    chk("reset g3 out_en", oe1, 0);
    run = 1;

    // Latency-1 select from IDLE
    drive(5'd5, 1, 0, 0, 0);
    chk("sel5 out_en", oe0, 32'h000020); chk("sel5 cur_code", cc0, 5);
    chk("sel5 busy", bz0, 0);

    // PC -> MDR with one dead cycle (g1), three dead cycles (g3)
    drive(5'd0, 0, 1, 0, 0);
    drive(5'd20, 1, 0, 0, 0);
    chk("pc out_en", oe0, 32'h100000);
    drive(5'd21, 1, 0, 0, 0);
    chk("pc-mdr gap out_en", oe0, 0); chk("pc-mdr gap busy", bz0, 1);
    idle(1);
    chk("mdr out_en", oe0, 32'h200000); chk("mdr busy", bz0, 0);
    chk("g3 mdr still gap", oe1, 0);
    idle(1);
    chk("g3 mdr still gap2", bz1, 1);
    idle(1);
    chk("g3 mdr out_en", oe1, 32'h200000);

    // Same code repeated: no dead cycle
    drive(5'd0, 0, 1, 0, 0);
    drive(5'd3, 1, 0, 0, 0);
    chk("r3 out_en", oe0, 32'h8);
    for (int i = 0; i < 4; i++) begin
      drive(5'd3, 1, 0, 0, 0);
      chk("r3 hold out_en", oe0, 32'h8); chk("r3 hold busy", bz0, 0);
      chk("r3 hold g3 out_en", oe1, 32'h8); chk("r3 hold g3 busy", bz1, 0);
    end

    // Illegal code in DRIVE: error, enable unchanged
    drive(5'd24, 1, 0, 0, 0);
    chk("drive ill out_en", oe0, 32'h8); chk("drive ill err", er0, 1);
    drive(5'd0, 0, 0, 1, 0);
    chk("clr err", er0, 0);

    // Illegal code in IDLE, clear, clear vs new illegal, release masking
    drive(5'd0, 0, 1, 0, 0);
    drive(5'd27, 1, 0, 0, 0);
    chk("idle ill err", er0, 1); chk("idle ill out_en", oe0, 0);
    drive(5'd0, 0, 0, 1, 0);
    chk("idle clr err", er0, 0);
    drive(5'd30, 1, 0, 1, 0);
    chk("clr+ill err", er0, 1);
    drive(5'd0, 0, 0, 1, 0);
    drive(5'd28, 1, 1, 0, 0);
    chk("rel masks ill err", er0, 0); chk("rel masks ill out_en", oe0, 0);
    drive(5'd31, 1, 0, 0, 0);
    chk("err reset later", er0, 1);

    // GAP_CYCLES=3: R0 -> HI, overwritten by LO in the second gap cycle
    drive(5'd0, 1, 0, 0, 0);
    chk("g3 r0 out_en", oe1, 32'h1);
    drive(5'd16, 1, 0, 0, 0);
    chk("g3 gap1 out_en", oe1, 0); chk("g3 gap1 busy", bz1, 1);
    idle(1);
    chk("g3 gap2 out_en", oe1, 0);
    drive(5'd17, 1, 0, 0, 0);
    chk("g3 gap3 out_en", oe1, 0); chk("g3 gap3 busy", bz1, 1);
    idle(1);
    chk("g3 lo out_en", oe1, 32'h020000); chk("g3 lo cur_code", cc1, 17);

    // Illegal code during GAP, then release during GAP
    drive(5'd5, 1, 0, 0, 0);
    chk("g3 gapB busy", bz1, 1);
    drive(5'd25, 1, 0, 0, 0);
    chk("g3 gap ill err", er1, 1); chk("g3 gap ill out_en", oe1, 0);
    drive(5'd0, 0, 1, 0, 0);
    chk("g3 rel out_en", oe1, 0); chk("g3 rel busy", bz1, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("g3 after rel out_en", oe1, 0);
    end

    // Release beats simultaneous select
    drive(5'd23, 1, 0, 0, 0);
    chk("c out_en", oe0, 32'h800000);
    drive(5'd2, 1, 1, 0, 0);
    chk("rel+sel out_en", oe0, 0); chk("rel+sel g3 out_en", oe1, 0);

    // Reset in the middle of a gap
    drive(5'd23, 1, 0, 0, 0);
    drive(5'd4, 1, 0, 0, 0);
    chk("pre-reset g3 busy", bz1, 1);
    drive(5'd0, 0, 0, 0, 1);
    chk("midgap rst out_en", oe1, 0); chk("midgap rst busy", bz1, 0);
    chk("midgap rst cur_code", cc1, 0); chk("midgap rst err", er1, 0);
    chk("midgap rst g1 err", er0, 0);
    idle(3);
    chk("post rst out_en", oe1, 0); chk("post rst g1 out_en", oe0, 0);

    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
